// File: rtl/picture_capture_writer_pkg.sv
// Shared definitions for the picture capture writer: FSM state codes,
// default RAM address width and RGB332 packing.
package picture_capture_writer_pkg;

  localparam int ADDR_W_DEFAULT = 20;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Keep the top bits of each 8-bit channel: 3 red, 3 green, 2 blue.
  function automatic logic [7:0] rgb332(input logic [23:0] p);
    rgb332_t c;
    c.r = p[23:21];
    c.g = p[15:13];
    c.b = p[7:6];
    return c;
  endfunction

endpackage

// File: rtl/picture_capture_writer_if.sv
// Write port of the dual-port image RAM as driven by the capture writer.
interface picture_capture_writer_if #(
  parameter int ADDR_W = 20
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_we, output mem_addr, output mem_data);
  modport slave  (input  mem_we, input  mem_addr, input  mem_data);
endinterface

// File: rtl/picture_capture_writer_addr_gen.sv
// Window geometry for the capture writer: in-window and last-pixel flags
// plus the RAM address, built from a per-line base accumulator.
module capture_window_addr_gen
  import picture_capture_writer_pkg::*;
#(
  parameter int WIDTH  = 1023,
  parameter int HEIGHT = 767,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic              restart,    // first evaluation of a new frame
  input  logic              commit,     // current pixel is being written
  input  logic [10:0]       x0,
  input  logic [9:0]        y0,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic              in_window,
  output logic              last_pixel,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] line_base_reg;
  logic [9:0]        cur_line_reg;
  logic              line_seen_reg;

  logic [11:0]       h12, x_lo, x_hi, v12, y_lo, y_hi;
  logic [ADDR_W-1:0] base_now, base_next;
  logic              seen_now;
  logic [10:0]       col_off;

  // 12-bit window bounds so x0+WIDTH / y0+HEIGHT cannot wrap.
  always_comb begin
    h12  = {1'b0, hcount};
    x_lo = {1'b0, x0};
    x_hi = x_lo + 12'(WIDTH);
    v12  = {2'b00, vcount};
    y_lo = {2'b00, y0};
    y_hi = y_lo + 12'(HEIGHT);
    in_window  = (h12 >= x_lo) && (h12 < x_hi) && (v12 >= y_lo) && (v12 < y_hi);
    last_pixel = in_window && (h12 == x_hi - 12'd1) && (v12 == y_hi - 12'd1);
  end

  // Row term: add WIDTH each time an in-window pixel lands on a new line.
  always_comb begin
    seen_now  = restart ? 1'b0 : line_seen_reg;
    base_now  = restart ? '0 : line_base_reg;
    base_next = (seen_now && (vcount != cur_line_reg)) ? base_now + ADDR_W'(WIDTH) : base_now;
    col_off   = hcount - x0;
    addr      = base_next + ADDR_W'(col_off);
  end

  // Track the line base of the last written pixel; clear while armed.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      line_base_reg <= '0;
      cur_line_reg  <= '0;
      line_seen_reg <= 1'b0;
    end else if (commit) begin
      line_base_reg <= base_next;
      cur_line_reg  <= vcount;
      line_seen_reg <= 1'b1;
    end else if (restart) begin
      line_base_reg <= '0;
      cur_line_reg  <= '0;
      line_seen_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/picture_capture_writer.sv
// Grabs a WIDTH x HEIGHT window of the live raster into an 8-bit RGB332
// image RAM, one frame per start request.
module picture_capture_writer
  import picture_capture_writer_pkg::*;
#(
  parameter int WIDTH  = 1023,
  parameter int HEIGHT = 767,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                     pixel_clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [10:0]              x,
  input  logic [9:0]               y,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic [23:0]              pixel,
  picture_capture_writer_if.master mem,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        pix_count
);

  logic [1:0]        state_reg;
  logic [10:0]       x0_reg;
  logic [9:0]        y0_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [7:0]        mem_data_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] pix_count_reg;

  logic              origin, evaluate, commit, restart;
  logic              in_window, last_pixel;
  logic [ADDR_W-1:0] gen_addr;

  // Decide whether the current raster pixel is considered for capture.
  // The origin pixel is evaluated on the ARMED->CAPTURE transition; an
  // origin seen while already capturing means the window ran off the raster.
  always_comb begin
    origin   = (hcount == 11'd0) && (vcount == 10'd0);
    evaluate = 1'b0;
    if (!abort) begin
      if (state_reg == ST_ARMED && origin)
        evaluate = 1'b1;
      else if (state_reg == ST_CAPTURE && !origin)
        evaluate = 1'b1;
    end
    commit  = evaluate && in_window;
    restart = (state_reg == ST_ARMED);
  end

  capture_window_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .restart    (restart),
    .commit     (commit),
    .x0         (x0_reg),
    .y0         (y0_reg),
    .hcount     (hcount),
    .vcount     (vcount),
    .in_window  (in_window),
    .last_pixel (last_pixel),
    .addr       (gen_addr)
  );

  // Capture FSM with registered RAM write port, done pulse and pixel counter.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      x0_reg        <= '0;
      y0_reg        <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      done_reg      <= 1'b0;
      pix_count_reg <= '0;
    end else begin
      mem_we_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            x0_reg        <= x;
            y0_reg        <= y;
            pix_count_reg <= '0;
            state_reg     <= ST_ARMED;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (evaluate) begin
            state_reg <= ST_CAPTURE;
            if (in_window) begin
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= gen_addr;
              mem_data_reg  <= rgb332(pixel);
              pix_count_reg <= pix_count_reg + 1'b1;
              if (last_pixel) begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
              end
            end
          end else if (state_reg == ST_CAPTURE) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_we   = mem_we_reg;
  assign mem.mem_addr = mem_addr_reg;
  assign mem.mem_data = mem_data_reg;
  assign busy         = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
  assign done         = done_reg;
  assign pix_count    = pix_count_reg;

endmodule

// File: tb/tb_picture_capture_writer.sv
// Self-checking bench for picture_capture_writer on a 16x8 raster with a
// 4x2 window; a frame-level reference model predicts every output cycle.
module tb_picture_capture_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HR = 16;
  localparam int VR = 8;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_CAP   = 2;
  localparam int M_DONE  = 3;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [10:0] x, hcount;
  logic [9:0]  y, vcount;
  logic [23:0] pixel;
  logic        busy, done;
  logic [19:0] pix_count;

  picture_capture_writer_if #(.ADDR_W(20)) mem_if ();

  picture_capture_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(20)) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .x         (x),
    .y         (y),
    .hcount    (hcount),
    .vcount    (vcount),
    .pixel     (pixel),
    .mem       (mem_if),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;
  int h = 0;
  int v = 0;
  int m_mode = M_IDLE;
  int m_x0, m_y0, m_cnt;
  int e_addr, e_data;
  bit e_we, e_done;
  int n_we, n_done;
  int done_addr;
  int data_3_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive raster and controls, advance the model, compare.
  task automatic tick(input bit rst, input bit s, input bit a, input int xi, input int yi);
    bit origin, evalp;
    reset_n = !rst;
    start   = s;
    abort   = a;
    x       = xi[10:0];
    y       = yi[9:0];
    hcount  = h[10:0];
    vcount  = v[9:0];
    pixel   = {h[7:0], v[7:0], 8'hC3};
    if (rst) begin
      m_mode = M_IDLE; m_x0 = 0; m_y0 = 0; m_cnt = 0;
      e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
    end else begin
      e_we = 0; e_done = 0;
      origin = (h == 0 && v == 0);
      evalp = 0;
      case (m_mode)
        M_IDLE:  if (s) begin m_x0 = xi; m_y0 = yi; m_cnt = 0; m_mode = M_ARMED; end
        M_ARMED: if (a) m_mode = M_IDLE;
                 else if (origin) begin m_mode = M_CAP; evalp = 1; end
        M_CAP:   if (a || origin) m_mode = M_IDLE; else evalp = 1;
        default: m_mode = M_IDLE;
      endcase
      if (evalp && h >= m_x0 && h < m_x0 + W && v >= m_y0 && v < m_y0 + H) begin
        e_we   = 1;
        e_addr = (h - m_x0) + (v - m_y0) * W;
        e_data = {24'd0, h[7:5], v[7:5], 2'b11};
        m_cnt++;
        if (m_cnt == W * H) begin m_mode = M_DONE; e_done = 1; end
      end
    end
    @(posedge pixel_clk);
    #1;
    chk("mem_we", {31'd0, mem_if.mem_we}, {31'd0, e_we});
    chk("mem_addr", {12'd0, mem_if.mem_addr}, e_addr);
    chk("mem_data", {24'd0, mem_if.mem_data}, e_data);
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("busy", {31'd0, busy}, (m_mode == M_ARMED || m_mode == M_CAP) ? 32'd1 : 32'd0);
    chk("pix_count", {12'd0, pix_count}, m_cnt);
    if (mem_if.mem_we === 1'b1) begin
      n_we++;
      if (h == 3 && v == 2) data_3_2 = int'(mem_if.mem_data);
    end
    if (done === 1'b1) begin
      n_done++;
      done_addr = int'(mem_if.mem_addr);
    end
    $display("t=%0t rst=%0d s=%0d a=%0d h=%0d v=%0d we=%0d addr=%0d data=%02h done=%0d busy=%0d cnt=%0d",
             $time, rst, s, a, h, v, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_data, done, busy, pix_count);
    h++;
    if (h == HR) begin h = 0; v = (v + 1) % VR; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic goto_pos(input int ht, input int vt);
    for (int i = 0; i < 2 * HR * VR && !(h == ht && v == vt); i++) tick(0, 0, 0, 0, 0);
    chk("goto_pos", (h == ht && v == vt) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic clear_stats();
    n_we = 0; n_done = 0; done_addr = -1; data_3_2 = -1;
  endtask

  initial begin
    clear_stats();
    // Reset state
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);

    // Reset mid-capture
    goto_pos(8, 7);
    tick(0, 1, 0, 2, 1);
    for (int i = 0; i < 400 && n_we < 2; i++) tick(0, 0, 0, 0, 0);
    chk("midcap_writes", (n_we >= 2) ? 32'd1 : 32'd0, 32'd1);
    clear_stats();
    tick(1, 0, 0, 0, 0);
    idle(2);
    chk("midcap_no_done", n_done, 0);

    // Basic grab at (2,1)
    clear_stats();
    goto_pos(4, 5);
    tick(0, 1, 0, 2, 1);
    idle(2 * HR * VR);
    chk("basic_writes", n_we, 8);
    chk("basic_done_cnt", n_done, 1);
    chk("basic_done_addr", done_addr, 7);
    chk("basic_data_3_2", data_3_2, 32'h03);
    chk("basic_pix_count", {12'd0, pix_count}, 8);
    chk("basic_busy_after", {31'd0, busy}, 0);

    // Arm mid-frame at (5,3): nothing until the next origin
    clear_stats();
    goto_pos(5, 3);
    tick(0, 1, 0, 2, 1);
    goto_pos(0, 0);
    chk("arm_no_early", n_we, 0);
    idle(HR * VR);
    chk("arm_writes", n_we, 8);
    chk("arm_done_cnt", n_done, 1);

    // Abort after the third write
    clear_stats();
    tick(0, 1, 0, 2, 1);
    for (int i = 0; i < 400 && n_we < 3; i++) tick(0, 0, 0, 0, 0);
    chk("abort_reach", n_we, 3);
    tick(0, 0, 1, 0, 0);
    idle(2 * HR * VR);
    chk("abort_writes", n_we, 3);
    chk("abort_pix_count", {12'd0, pix_count}, 3);
    chk("abort_no_done", n_done, 0);

    // Window clipped by the raster edge
    clear_stats();
    tick(0, 1, 0, 14, 7);
    idle(2 * HR * VR);
    chk("clip_writes", n_we, 2);
    chk("clip_no_done", n_done, 0);
    chk("clip_pix_count", {12'd0, pix_count}, 2);
    chk("clip_busy", {31'd0, busy}, 0);

    // start while armed is ignored; start+abort in ARMED aborts
    clear_stats();
    goto_pos(3, 2);
    tick(0, 1, 0, 2, 1);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    idle(2 * HR * VR);
    chk("startabort_writes", n_we, 0);
    chk("startabort_busy", {31'd0, busy}, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 600) == 0, ($urandom % 40) == 0, ($urandom % 150) == 0,
           int'($urandom_range(0, 17)), int'($urandom_range(0, 9)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
